// File: rtl/dvsd_pe_pkg.sv
// Shared constants and types for the dvsd_pe priority-encoder request path.
package dvsd_pe_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } req_state_t;

  typedef logic [CODE_W-1:0] req_id_t;

endpackage

// File: rtl/dvsd_sync2.sv
// Per-bit two-flop synchronizer for asynchronous request lines.
// Only instantiated when PE_REQ_SYNC_EN is defined.
module dvsd_sync2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dvsd_pe_req_latch.sv
// Request capture / grant handshake in front of the dvsd_pe priority encoder.
// Define PE_REQ_SYNC_EN to put a two-flop synchronizer on every req_in bit.
module dvsd_pe_req_latch #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  req_in,
  input  logic              mask_wr,
  input  logic [WIDTH-1:0]  mask_din,
  output logic [WIDTH-1:0]  pe_in,
  output logic              pe_en,
  input  logic [CODE_W-1:0] pe_out,
  input  logic              pe_gs,
  output logic              irq,
  output logic [CODE_W-1:0] irq_id,
  input  logic              ack,
  output logic              lost
);

  import dvsd_pe_pkg::*;

  logic [WIDTH-1:0]  s;
  logic [WIDTH-1:0]  s_d_q;
  logic [WIDTH-1:0]  rise;
  logic [WIDTH-1:0]  clr;
  logic [WIDTH-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  pe_in_q;
  logic [CODE_W-1:0] irq_id_q, irq_id_d;
  req_state_t        state_q, state_d;
  logic              irq_q;
  logic              pe_en_q;
  logic              lost_q, lost_d;

`ifdef PE_REQ_SYNC_EN
  dvsd_sync2 #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (req_in),
    .q_o   (s)
  );
`else
  assign s = req_in;
`endif

  // Edge detector history; comes out of reset low so a held line gives one rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d_q <= '0;
    else        s_d_q <= s;
  end

  // Grant handshake: latch the encoder result, hold it until ack.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    clr      = '0;
    case (state_q)
      IDLE: begin
        if (pe_gs) begin
          irq_id_d = pe_out;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          clr     = WIDTH'(1) << irq_id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh rise on the bit being cleared wins, so the new request survives.
  always_comb begin
    rise   = s & ~s_d_q;
    pend_d = (pend_q & ~clr) | rise;
    lost_d = |(rise & pend_q & ~clr);
    mask_d = mask_wr ? mask_din : mask_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      irq_id_q <= '0;
      pend_q   <= '0;
      mask_q   <= '1;
      pe_in_q  <= '0;
      pe_en_q  <= 1'b1;
      irq_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_id_q <= irq_id_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      pe_in_q  <= pend_d & mask_d;
      pe_en_q  <= (state_d == IDLE);
      irq_q    <= (state_d == GRANT);
      lost_q   <= lost_d;
    end
  end

  assign pe_in  = pe_in_q;
  assign pe_en  = pe_en_q;
  assign irq    = irq_q;
  assign irq_id = irq_id_q;
  assign lost   = lost_q;

endmodule
